// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills the IF/ID register.
// Redirects (branch, jump) squash the in-flight fetch; halt freezes fetching until reset.
//
// state | meaning
// BOOT  | first cycle after reset: PC held, bubble into IF/ID
// RUN   | normal fetch with branch > jump > stall > halt > sequential priority
// HALT  | PC frozen, bubble every cycle, only rst_n leaves
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  opcode,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_plus4;

    // Redirect targets are word-aligned, so their low bits are dropped.
    logic unused_target_bits;
    assign unused_target_bits = ^{branch_target[1:0], jump_target[1:0]};

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_BOOT: begin
                ifid_instr_d = 32'h0;
                ifid_valid_d = 1'b0;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d         = {branch_target[31:2], 2'b00};
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                end else if (jump) begin
                    pc_d         = {jump_target[31:2], 2'b00};
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt) begin
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                    state_d      = ST_HALT;
                end else begin
                    ifid_instr_d = instr_rdata;
                    ifid_pc4_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                    if (fetch_count_q != 16'hFFFF) begin
                        fetch_count_d = fetch_count_q + 16'd1;
                    end
                end
            end
            ST_HALT: begin
                ifid_instr_d = 32'h0;
                ifid_valid_d = 1'b0;
            end
            default: begin
                ifid_instr_d = 32'h0;
                ifid_valid_d = 1'b0;
                state_d      = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            ifid_instr_q  <= 32'h0;
            ifid_pc4_q    <= 32'h0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 16'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_valid  = ifid_valid_q;
    assign opcode      = ifid_instr_q[31:26];
    assign fetch_count = fetch_count_q;

endmodule
